apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter and sequencer that shares the single APB master bridge command port (transfer, read_write, write/read address, write data) among NUM_REQ local requesters. It sits directly in front of the 2-slave APB bridge. It accepts one held request per requester, issues the winning command to the bridge, and waits for the bridge's completion pulse. It then returns read data plus a one-cycle acknowledge to the winner.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- AW, 9, address width; MSB selects slave inside the bridge
- DW, 8, data width
- TIMEOUT_CYCLES, 16, watchdog limit in cycles (used only with APB_ARB_TIMEOUT_EN)

- pclk  input  1  APB clock; all logic on rising edge
- preset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request; held high until its req_ack
- req_rw  input  NUM_REQ  per-requester direction; 1 = read, 0 = write
- req_addr  input  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  input  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
- req_ack  output  NUM_REQ  one-hot, one-cycle completion to the granted requester
- req_rdata  output  DW  read data; valid only while req_ack is nonzero and the request was a read
- req_err  output  1  timeout flag qualified by req_ack (only with APB_ARB_TIMEOUT_EN; otherwise tied 0)
- transfer  output  1  command valid to the bridge
- read_write  output  1  1 = read, 0 = write
- apb_write_paddr  output  AW  write address
- apb_write_data  output  DW  write data
- apb_read_paddr  output  AW  read address
- apb_read_data_out  input  DW  read data from the bridge
- bridge_done  input  1  one-cycle pulse: bridge finished the current transfer

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, any req_valid high:
  - pick the winner by round-robin starting at pointer ptr;
  - latch winner index, rw, addr and wdata;
  - go to BUSY.
- BUSY:
  - drive transfer=1 and read_write = latched rw.
  - Write: apb_write_paddr/apb_write_data = latched values; apb_read_paddr = 0.
  - Read: apb_read_paddr = latched addr; write address and data = 0.
  - On bridge_done: capture apb_read_data_out (read) or 0 (write) and go to RESP.
- RESP:
  - drive req_ack[winner]=1 and req_rdata = captured value;
  - set ptr = (winner+1) mod NUM_REQ;
  - go to IDLE.
- Requester protocol: drop req_valid, or present a new request, on the cycle after req_ack. Command fields must be stable while valid is high.
- Commands are latched, so requester changes after the grant do not affect the bridge.
- bridge_done outside BUSY is ignored.
- A req_valid deassertion after the grant is not supported; the transfer still completes.

## Timing
- Reset values: transfer, read_write, all address and data outputs, req_ack, req_rdata and req_err are 0; state = IDLE; ptr = 0.
- All outputs are registered.
- Request sampled in IDLE at cycle N: transfer is high from N+1.
- bridge_done at cycle M: transfer low and req_ack high at M+1; state IDLE at M+2.
- Minimum request-to-ack: 3 cycles. Back-to-back throughput: one transfer per (bridge latency + 2) cycles.
- preset mid-transfer: return to IDLE on the next edge, with no ack for the in-flight request. A bridge_done that arrives later is ignored.
- Simultaneous requests: served in order ptr, ptr+1, …, wrapping. With all valid high from reset, grants go 0,1,2,3,0…
- ptr wraps from NUM_REQ-1 to 0.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - an 8-bit-minimum counter clears on entry to BUSY and increments each BUSY cycle;
  - when it reaches TIMEOUT_CYCLES without bridge_done, drop transfer, go to RESP with req_err=1 and req_rdata=0;
  - ptr advances as normal.
- APB_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; req_err is constant 0.

## Structure
- Package apb_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - default AW/DW/NUM_REQ localparams;
  - a clog2-based index width constant.
- Sub-module apb_rr_picker: combinational rotate-priority-rotate-back picker. Inputs: req vector and ptr. Outputs: grant index and any-request flag.
- The top holds the FSM, command latches, ptr and the optional watchdog.

## Test plan
- Single write: req 2 writes addr 0x105, data 0xA5; bridge_done 2 cycles after transfer → bridge sees read_write=0, paddr 0x105, data 0xA5; req_ack=4'b0100 one cycle after done.
- Single read: req 0 reads 0x013; bridge returns 0x3C with done → req_rdata=0x3C with req_ack=4'b0001.
- Contention: all four valid from reset, each re-requesting after ack → grant order 0,1,2,3,0; no requester granted twice before the others.
- Pointer wrap: ptr=3, req 1 and 3 valid → 3 first, then 1.
- Reset mid-transfer: preset in BUSY, then bridge_done → no ack; all outputs 0; next request granted from ptr=0.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): withhold bridge_done → transfer drops after 16 BUSY cycles; req_ack plus req_err=1, req_rdata=0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared constants for the APB request arbiter: state encoding, default sizes, width helpers.
package apb_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_AW      = 9;
    localparam int unsigned DEF_DW      = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Watchdog counter is never narrower than 8 bits.
    function automatic int unsigned cnt_w(input int unsigned limit);
        return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: rotate requests by ptr, take lowest set bit, rotate index back.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = DEF_IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum       = {1'b0, off} + {1'b0, ptr};
        grant_idx = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
        any_req   = |req;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sequencer sharing one APB bridge command port among NUM_REQ requesters.
// Optional watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned AW             = DEF_AW,
    parameter int unsigned DW             = DEF_DW,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_rw,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [DW-1:0]         req_rdata,
    output logic                  req_err,
    output logic                  transfer,
    output logic                  read_write,
    output logic [AW-1:0]         apb_write_paddr,
    output logic [DW-1:0]         apb_write_data,
    output logic [AW-1:0]         apb_read_paddr,
    input  logic [DW-1:0]         apb_read_data_out,
    input  logic                  bridge_done
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    state_t               state, state_nxt;
    logic [IW-1:0]        ptr, ptr_nxt, win, win_nxt, pick_idx;
    logic                 pick_any;
    logic [AW-1:0]        pick_addr;
    logic [DW-1:0]        pick_wdata;
    logic                 timeout_c;

    logic                 transfer_nxt, read_write_nxt, err_nxt;
    logic [AW-1:0]        wpaddr_nxt, rpaddr_nxt;
    logic [DW-1:0]        wdata_nxt, rdata_nxt;
    logic [NUM_REQ-1:0]   ack_nxt;

    apb_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IW)) u_picker (
        .req       (req_valid),
        .ptr       (ptr),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    assign pick_addr  = req_addr[pick_idx*AW +: AW];
    assign pick_wdata = req_wdata[pick_idx*DW +: DW];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_w(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wd_cnt;

    // Held at zero outside BUSY, so it starts from zero on every BUSY entry.
    always_ff @(posedge pclk) begin
        if (preset || state != BUSY) wd_cnt <= '0;
        else                         wd_cnt <= wd_cnt + CNT_W'(1);
    end

    assign timeout_c = (state == BUSY) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_c      = 1'b0;
`endif

    // Next-state and next-output logic; the output registers double as command latches.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        win_nxt        = win;
        transfer_nxt   = transfer;
        read_write_nxt = read_write;
        wpaddr_nxt     = apb_write_paddr;
        wdata_nxt      = apb_write_data;
        rpaddr_nxt     = apb_read_paddr;
        ack_nxt        = '0;
        rdata_nxt      = '0;
        err_nxt        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt      = BUSY;
                    win_nxt        = pick_idx;
                    transfer_nxt   = 1'b1;
                    read_write_nxt = req_rw[pick_idx];
                    if (req_rw[pick_idx]) begin
                        rpaddr_nxt = pick_addr;
                        wpaddr_nxt = '0;
                        wdata_nxt  = '0;
                    end else begin
                        rpaddr_nxt = '0;
                        wpaddr_nxt = pick_addr;
                        wdata_nxt  = pick_wdata;
                    end
                end
            end
            BUSY: begin
                if (bridge_done || timeout_c) begin
                    state_nxt      = RESP;
                    transfer_nxt   = 1'b0;
                    read_write_nxt = 1'b0;
                    wpaddr_nxt     = '0;
                    wdata_nxt      = '0;
                    rpaddr_nxt     = '0;
                    ack_nxt        = NUM_REQ'(1) << win;
                    rdata_nxt      = (bridge_done && read_write) ? apb_read_data_out : '0;
                    err_nxt        = !bridge_done;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                ptr_nxt   = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state           <= IDLE;
            ptr             <= '0;
            win             <= '0;
            transfer        <= 1'b0;
            read_write      <= 1'b0;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
            apb_read_paddr  <= '0;
            req_ack         <= '0;
            req_rdata       <= '0;
            req_err         <= 1'b0;
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            win             <= win_nxt;
            transfer        <= transfer_nxt;
            read_write      <= read_write_nxt;
            apb_write_paddr <= wpaddr_nxt;
            apb_write_data  <= wdata_nxt;
            apb_read_paddr  <= rpaddr_nxt;
            req_ack         <= ack_nxt;
            req_rdata       <= rdata_nxt;
            req_err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed-vector bench for apb_req_arbiter (4 requesters, AW=9, DW=8).
module tb_apb_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;

    logic            pclk = 1'b0;
    logic            preset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   req_rdata;
    logic            req_err;
    logic            transfer;
    logic            read_write;
    logic [AW-1:0]   apb_write_paddr;
    logic [DW-1:0]   apb_write_data;
    logic [AW-1:0]   apb_read_paddr;
    logic [DW-1:0]   apb_read_data_out;
    logic            bridge_done;

    apb_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .pclk              (pclk),
        .preset            (preset),
        .req_valid         (req_valid),
        .req_rw            (req_rw),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ack           (req_ack),
        .req_rdata         (req_rdata),
        .req_err           (req_err),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .bridge_done       (bridge_done)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] rw;
        int         lat;
        logic [7:0] rd;
        logic       exp_rw;
        logic [8:0] exp_wa;
        logic [7:0] exp_wd;
        logic [8:0] exp_ra;
        logic [3:0] exp_ack;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tab [8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Polls for transfer, bounded; reports the number of negedges waited.
    task automatic wait_transfer(input string name, output int n);
        n = 0;
        while (transfer !== 1'b1 && n < 8) begin
            @(negedge pclk);
            n++;
        end
        if (transfer !== 1'b1) chk({name, "_xfer_timeout"}, 64'(transfer), 64'(1));
    endtask

    task automatic pulse_done(input logic [7:0] rd);
        bridge_done       = 1'b1;
        apb_read_data_out = rd;
        @(negedge pclk);
        bridge_done       = 1'b0;
        apb_read_data_out = 8'h00;
    endtask

    initial begin
        int   n;
        logic [3:0] exp_ack;

        // Requester i: addr a_i, data w_i.
        req_addr  = {9'h1F0, 9'h105, 9'h0AA, 9'h013};
        req_wdata = {8'hC3, 8'hA5, 8'h11, 8'h5A};

        tab[0] = '{4'b0100, 4'b0000, 2, 8'h00, 1'b0, 9'h105, 8'hA5, 9'h000, 4'b0100, 8'h00};
        tab[1] = '{4'b1010, 4'b1000, 1, 8'h77, 1'b1, 9'h000, 8'h00, 9'h1F0, 4'b1000, 8'h77};
        tab[2] = '{4'b1010, 4'b1000, 0, 8'hFF, 1'b0, 9'h0AA, 8'h11, 9'h000, 4'b0010, 8'h00};
        tab[3] = '{4'b0001, 4'b0001, 2, 8'h3C, 1'b1, 9'h000, 8'h00, 9'h013, 4'b0001, 8'h3C};
        tab[4] = '{4'b1111, 4'b0101, 1, 8'h00, 1'b0, 9'h0AA, 8'h11, 9'h000, 4'b0010, 8'h00};
        tab[5] = '{4'b1111, 4'b0101, 3, 8'hE7, 1'b1, 9'h000, 8'h00, 9'h105, 4'b0100, 8'hE7};
        tab[6] = '{4'b1100, 4'b1000, 0, 8'h9D, 1'b1, 9'h000, 8'h00, 9'h1F0, 4'b1000, 8'h9D};
        tab[7] = '{4'b1100, 4'b1000, 2, 8'h42, 1'b0, 9'h105, 8'hA5, 9'h000, 4'b0100, 8'h00};

        preset            = 1'b1;
        req_valid         = '0;
        req_rw            = '0;
        bridge_done       = 1'b0;
        apb_read_data_out = '0;
        repeat (2) @(negedge pclk);
        chk("reset_outputs",
            64'({transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr, req_ack, req_rdata, req_err}),
            64'(0));
        preset = 1'b0;
        @(negedge pclk);

        // Table: each record is one complete transaction starting from IDLE.
        for (int v = 0; v < 8; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            req_valid = tab[v].valid;
            req_rw    = tab[v].rw;
            @(negedge pclk);
            chk({nm, "_cmd"},
                64'({transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr}),
                64'({1'b1, tab[v].exp_rw, tab[v].exp_wa, tab[v].exp_wd, tab[v].exp_ra}));
            for (int k = 0; k < tab[v].lat; k++) @(negedge pclk);
            chk({nm, "_busy"}, 64'({transfer, req_ack}), 64'({1'b1, 4'b0000}));
            pulse_done(tab[v].rd);
            chk({nm, "_ack"}, 64'({transfer, req_ack, req_rdata, req_err}),
                64'({1'b0, tab[v].exp_ack, tab[v].exp_rdata, 1'b0}));
            req_valid = '0;
            @(negedge pclk);
            chk({nm, "_ack_once"}, 64'({transfer, req_ack}), 64'(0));
        end

        // Contention from reset with all requesters held valid.
        preset    = 1'b1;
        req_valid = 4'b1111;
        req_rw    = 4'b0000;
        @(negedge pclk);
        preset = 1'b0;
        for (int g = 0; g < 5; g++) begin
            wait_transfer("rr", n);
            pulse_done(8'h00);
            exp_ack = 4'b0001 << (g % 4);
            chk($sformatf("rr_grant%0d", g), 64'(req_ack), 64'(exp_ack));
            @(negedge pclk);
        end
        req_valid = '0;
        repeat (2) @(negedge pclk);

        // Reset mid-transfer: no ack, late done ignored, ptr back to 0.
        req_valid = 4'b0100;
        wait_transfer("rst_mid", n);
        chk("rst_mid_busy", 64'({transfer, apb_write_paddr}), 64'({1'b1, 9'h105}));
        preset    = 1'b1;
        req_valid = '0;
        @(negedge pclk);
        preset = 1'b0;
        chk("rst_mid_outputs",
            64'({transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr, req_ack, req_rdata, req_err}),
            64'(0));
        pulse_done(8'h55);
        chk("rst_mid_no_ack", 64'({transfer, req_ack}), 64'(0));
        @(negedge pclk);
        chk("rst_mid_no_ack2", 64'({transfer, req_ack}), 64'(0));
        req_valid = 4'b1001;
        req_rw    = 4'b0000;
        @(negedge pclk);
        chk("rst_mid_ptr0_cmd",
            64'({transfer, read_write, apb_write_paddr, apb_write_data}),
            64'({1'b1, 1'b0, 9'h013, 8'h5A}));
        pulse_done(8'h00);
        chk("rst_mid_ptr0_ack", 64'(req_ack), 64'(4'b0001));
        req_valid = '0;
        repeat (2) @(negedge pclk);

`ifdef APB_ARB_TIMEOUT_EN
        // Watchdog: no bridge_done, transfer drops after 16 BUSY cycles.
        req_valid = 4'b0010;
        req_rw    = 4'b0010;
        @(negedge pclk);
        n = 0;
        while (transfer === 1'b1 && n < 40) begin
            n++;
            @(negedge pclk);
        end
        chk("wd_busy_cycles", 64'(n), 64'(16));
        chk("wd_resp", 64'({req_ack, req_rdata, req_err}), 64'({4'b0010, 8'h00, 1'b1}));
        req_valid = '0;
        @(negedge pclk);
        chk("wd_err_once", 64'({req_ack, req_err}), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
